// File: rtl/osc_trigger_capture_pkg.sv
// Shared state encodings and default widths for the oscilloscope trigger/capture path.
package osc_trigger_capture_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRE_FILL  = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } cap_state_t;

endpackage

// File: rtl/osc_sample_ram.sv
// Capture buffer: DEPTH x DATA_W simple dual-port RAM, synchronous write and
// registered read; the read register clears on reset so readout starts at 0.
module osc_sample_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
   logic [DATA_W-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) r_rd_data <= '0;
      else     r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/osc_trigger_capture.sv
// Level-crossing trigger with pre/post window capture into a circular buffer.
// Define OSC_CAP_AUTO_TRIG_EN to force a trigger after DEPTH samples without a crossing.
module osc_trigger_capture
   import osc_trigger_capture_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int PRE_TRIG = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_slope,
   input  logic              arm,
   output logic              busy,
   output logic              capture_done,
   output logic              triggered,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [2:0]        o_dbg_state
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PRE_PTR   = ADDR_W'(PRE_TRIG);
   localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
   localparam logic [ADDR_W-1:0] POST_LOAD = ADDR_W'(DEPTH - PRE_TRIG - 1);
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

   cap_state_t        r_state;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_start_ptr;
   logic [ADDR_W-1:0] r_pre_cnt;
   logic [ADDR_W-1:0] r_post_cnt;
   logic [DATA_W-1:0] r_prev;
   logic              r_prev_valid;
   logic              r_busy;
   logic              r_done;
   logic              r_triggered;

   logic              w_capturing;
   logic              w_wr_en;
   logic              w_rise;
   logic              w_fall;
   logic              w_cross;
   logic              w_fire;
   logic [ADDR_W-1:0] w_rd_addr;

   assign w_capturing = (r_state == ST_PRE_FILL) || (r_state == ST_WAIT_TRIG) ||
                        (r_state == ST_POST);
   assign w_wr_en     = w_capturing && sample_valid;

   // prev_valid is cleared on arm, so the first sample of a capture cannot trigger.
   assign w_rise  = (r_prev < trig_level) && (sample_data >= trig_level);
   assign w_fall  = (r_prev > trig_level) && (sample_data <= trig_level);
   assign w_cross = r_prev_valid && (trig_slope ? w_fall : w_rise);

`ifdef OSC_CAP_AUTO_TRIG_EN
   logic [ADDR_W-1:0] r_to_cnt;
   logic              w_force;
   // All-ones means DEPTH-1 samples already seen: this one is the DEPTH-th.
   assign w_force = (r_to_cnt == '1);
   assign w_fire  = w_cross || w_force;
`else
   assign w_fire  = w_cross;
`endif

   assign w_rd_addr = r_start_ptr + rd_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_wr_ptr     <= '0;
         r_start_ptr  <= '0;
         r_pre_cnt    <= '0;
         r_post_cnt   <= '0;
         r_prev       <= '0;
         r_prev_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_triggered  <= 1'b0;
`ifdef OSC_CAP_AUTO_TRIG_EN
         r_to_cnt     <= '0;
`endif
      end else begin
         if (w_wr_en) begin
            r_wr_ptr     <= r_wr_ptr + ONE;
            r_prev       <= sample_data;
            r_prev_valid <= 1'b1;
         end
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (arm) begin
                  r_state      <= ST_PRE_FILL;
                  r_pre_cnt    <= '0;
                  r_prev_valid <= 1'b0;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
`ifdef OSC_CAP_AUTO_TRIG_EN
                  r_to_cnt     <= '0;
`endif
               end
            end
            ST_PRE_FILL: begin
               if (sample_valid) begin
                  if (r_pre_cnt == PRE_LAST) r_state <= ST_WAIT_TRIG;
                  else                       r_pre_cnt <= r_pre_cnt + ONE;
               end
            end
            ST_WAIT_TRIG: begin
               if (sample_valid) begin
`ifdef OSC_CAP_AUTO_TRIG_EN
                  r_to_cnt <= r_to_cnt + ONE;
`endif
                  if (w_fire) begin
                     r_start_ptr <= r_wr_ptr - PRE_PTR;
                     r_post_cnt  <= POST_LOAD;
                     r_triggered <= w_cross;
                     if (POST_LOAD == '0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= ST_POST;
                     end
                  end
               end
            end
            ST_POST: begin
               if (sample_valid) begin
                  r_post_cnt <= r_post_cnt - ONE;
                  if (r_post_cnt == ONE) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   osc_sample_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (sample_data),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (rd_data)
   );

   assign busy         = r_busy;
   assign capture_done = r_done;
   assign triggered    = r_triggered;
   assign o_dbg_state  = r_state;

endmodule
